// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: ALU function codes,
// opcode/funct values, FSM states and datapath mux select codes.
package mips_ctrl_pkg;

  localparam logic [5:0] ALU_ADD    = 6'b000000;
  localparam logic [5:0] ALU_SUB    = 6'b000001;
  localparam logic [5:0] ALU_AND    = 6'b011000;
  localparam logic [5:0] ALU_OR     = 6'b011110;
  localparam logic [5:0] ALU_XOR    = 6'b010110;
  localparam logic [5:0] ALU_NOR    = 6'b010001;
  localparam logic [5:0] ALU_PASS_A = 6'b011010;
  localparam logic [5:0] ALU_SLL    = 6'b100000;
  localparam logic [5:0] ALU_SRL    = 6'b100001;
  localparam logic [5:0] ALU_SRA    = 6'b100011;
  localparam logic [5:0] ALU_EQ     = 6'b110011;
  localparam logic [5:0] ALU_NEQ    = 6'b110001;
  localparam logic [5:0] ALU_LT     = 6'b110101;
  localparam logic [5:0] ALU_LEZ    = 6'b111101;
  localparam logic [5:0] ALU_LTZ    = 6'b111011;
  localparam logic [5:0] ALU_GTZ    = 6'b111111;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

  localparam logic [2:0] PC_SRC_ALU    = 3'd0;
  localparam logic [2:0] PC_SRC_ALUOUT = 3'd1;
  localparam logic [2:0] PC_SRC_JUMP   = 3'd2;
  localparam logic [2:0] PC_SRC_RS     = 3'd3;

  localparam logic [1:0] REG_DST_RT  = 2'd0;
  localparam logic [1:0] REG_DST_RD  = 2'd1;
  localparam logic [1:0] REG_DST_R31 = 2'd2;
  localparam logic [1:0] REG_DST_R26 = 2'd3;

  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

  localparam logic [1:0] SRC_A_PC    = 2'd0;
  localparam logic [1:0] SRC_A_RS    = 2'd1;
  localparam logic [1:0] SRC_A_SHAMT = 2'd2;
  localparam logic [1:0] SRC_A_C16   = 2'd3;

  localparam logic [1:0] SRC_B_RT     = 2'd0;
  localparam logic [1:0] SRC_B_C4     = 2'd1;
  localparam logic [1:0] SRC_B_IMM    = 2'd2;
  localparam logic [1:0] SRC_B_IMM_SH = 2'd3;

  function automatic logic is_shift_funct(input logic [5:0] fn);
    return (fn == FN_SLL) || (fn == FN_SRL) || (fn == FN_SRA);
  endfunction

endpackage

// File: rtl/alu_fun_decode.sv
// Combinational instruction decode to ALU function, signed mode, immediate
// extension and a legality flag for the multi-cycle control FSM.
module alu_fun_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output logic [5:0] o_alu_fun,
  output logic       o_sign,
  output logic       o_ext_sign,
  output logic       o_valid
);

  always_comb begin
    o_alu_fun  = ALU_ADD;
    o_sign     = 1'b0;
    o_ext_sign = 1'b1;
    o_valid    = 1'b1;
    case (i_opcode)
      OP_RTYPE: begin
        case (i_funct)
          FN_SLL:  o_alu_fun = ALU_SLL;
          FN_SRL:  o_alu_fun = ALU_SRL;
          FN_SRA:  o_alu_fun = ALU_SRA;
          FN_JR, FN_JALR, FN_ADDU: o_alu_fun = ALU_ADD;
          FN_ADD:  begin o_alu_fun = ALU_ADD; o_sign = 1'b1; end
          FN_SUB:  begin o_alu_fun = ALU_SUB; o_sign = 1'b1; end
          FN_SUBU: o_alu_fun = ALU_SUB;
          FN_AND:  o_alu_fun = ALU_AND;
          FN_OR:   o_alu_fun = ALU_OR;
          FN_XOR:  o_alu_fun = ALU_XOR;
          FN_NOR:  o_alu_fun = ALU_NOR;
          FN_SLT:  begin o_alu_fun = ALU_LT; o_sign = 1'b1; end
          FN_SLTU: o_alu_fun = ALU_LT;
          default: o_valid = 1'b0;
        endcase
      end
      // REGIMM is decoded as bltz; rt is not inspected here
      OP_REGIMM: begin o_alu_fun = ALU_LTZ; o_sign = 1'b1; end
      OP_J, OP_JAL, OP_ADDIU, OP_LW, OP_SW: o_alu_fun = ALU_ADD;
      OP_BEQ:   begin o_alu_fun = ALU_EQ;  o_sign = 1'b1; end
      OP_BNE:   begin o_alu_fun = ALU_NEQ; o_sign = 1'b1; end
      OP_BLEZ:  begin o_alu_fun = ALU_LEZ; o_sign = 1'b1; end
      OP_BGTZ:  begin o_alu_fun = ALU_GTZ; o_sign = 1'b1; end
      OP_ADDI:  begin o_alu_fun = ALU_ADD; o_sign = 1'b1; end
      OP_SLTI:  begin o_alu_fun = ALU_LT;  o_sign = 1'b1; end
      OP_SLTIU: o_alu_fun = ALU_LT;
      OP_ANDI:  begin o_alu_fun = ALU_AND; o_ext_sign = 1'b0; end
      OP_ORI:   begin o_alu_fun = ALU_OR;  o_ext_sign = 1'b0; end
      OP_XORI:  begin o_alu_fun = ALU_XOR; o_ext_sign = 1'b0; end
      OP_LUI:   begin o_alu_fun = ALU_SLL; o_ext_sign = 1'b0; end
      default:  o_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM driving the ALU and datapath enables.
// Optional macro UNDEF_TRAP_EN adds a TRAP state for undefined instructions.
//
// state  | meaning
// FETCH  | read instruction, PC <= PC+4 when memory ready
// DECODE | compute branch target into ALUOut, resolve jumps
// EXEC   | ALU operation, address calculation or branch compare
// MEM    | data memory access, held until memory ready
// WB     | register file write-back
// TRAP   | undefined instruction: save PC+4 in r26, jump to vector
module mc_ctrl_fsm
  import mips_ctrl_pkg::*;
#(
  parameter logic [2:0] EXC_VECTOR_SEL = 3'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        alu_flag,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic [2:0]  pc_src,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        i_or_d,
  output logic        reg_write,
  output logic [1:0]  reg_dst,
  output logic [1:0]  mem_to_reg,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        ext_sign,
  output logic [5:0]  alu_fun,
  output logic        sign,
  output logic        exc_flag
);

  state_t r_state;

  logic [5:0] w_opcode, w_funct, w_alu_fun;
  logic       w_sign, w_ext_sign, w_valid;
  logic       w_is_rtype, w_is_shift, w_is_j, w_is_jal, w_is_jr, w_is_jalr;
  logic       w_is_jump, w_is_branch, w_is_lw, w_is_sw, w_is_lui;
  logic       w_unused;

  assign w_opcode    = instr[31:26];
  assign w_funct     = instr[5:0];
  assign w_is_rtype  = (w_opcode == OP_RTYPE);
  assign w_is_shift  = w_is_rtype && is_shift_funct(w_funct);
  assign w_is_j      = (w_opcode == OP_J);
  assign w_is_jal    = (w_opcode == OP_JAL);
  assign w_is_jr     = w_is_rtype && (w_funct == FN_JR);
  assign w_is_jalr   = w_is_rtype && (w_funct == FN_JALR);
  assign w_is_jump   = w_is_j || w_is_jal || w_is_jr || w_is_jalr;
  assign w_is_branch = (w_opcode == OP_BEQ) || (w_opcode == OP_BNE) ||
                       (w_opcode == OP_BLEZ) || (w_opcode == OP_BGTZ) ||
                       (w_opcode == OP_REGIMM);
  assign w_is_lw     = (w_opcode == OP_LW);
  assign w_is_sw     = (w_opcode == OP_SW);
  assign w_is_lui    = (w_opcode == OP_LUI);

`ifdef UNDEF_TRAP_EN
  assign w_unused = ^instr[25:6];
`else
  assign w_unused = ^{instr[25:6], EXC_VECTOR_SEL};
`endif

  alu_fun_decode u_alu_fun_decode (
    .i_opcode   (w_opcode),
    .i_funct    (w_funct),
    .o_alu_fun  (w_alu_fun),
    .o_sign     (w_sign),
    .o_ext_sign (w_ext_sign),
    .o_valid    (w_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FETCH;
    end else begin
      case (r_state)
        FETCH:  if (mem_ready) r_state <= DECODE;
        DECODE: begin
          if (!w_valid) begin
`ifdef UNDEF_TRAP_EN
            r_state <= TRAP;
`else
            r_state <= FETCH;
`endif
          end else if (w_is_jump) begin
            r_state <= FETCH;
          end else begin
            r_state <= EXEC;
          end
        end
        EXEC: begin
          if (w_is_branch)            r_state <= FETCH;
          else if (w_is_lw || w_is_sw) r_state <= MEM;
          else                         r_state <= WB;
        end
        MEM:     if (mem_ready) r_state <= w_is_lw ? WB : FETCH;
        WB:      r_state <= FETCH;
        default: r_state <= FETCH;
      endcase
    end
  end

  always_comb begin
    pc_write   = 1'b0;
    pc_src     = PC_SRC_ALU;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = REG_DST_RT;
    mem_to_reg = M2R_ALUOUT;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_C4;
    ext_sign   = 1'b1;
    alu_fun    = ALU_ADD;
    sign       = 1'b0;
    exc_flag   = 1'b0;
    case (r_state)
      FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
      end
      DECODE: begin
        alu_src_b = SRC_B_IMM_SH;
        if (w_valid) begin
          if (w_is_j || w_is_jal) begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_JUMP;
          end
          if (w_is_jr || w_is_jalr) begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_RS;
          end
          if (w_is_jal || w_is_jalr) begin
            reg_write  = 1'b1;
            reg_dst    = w_is_jal ? REG_DST_R31 : REG_DST_RD;
            mem_to_reg = M2R_PC;
          end
        end
      end
      EXEC: begin
        alu_fun   = w_alu_fun;
        sign      = w_sign;
        ext_sign  = w_ext_sign;
        alu_src_a = w_is_shift ? SRC_A_SHAMT : (w_is_lui ? SRC_A_C16 : SRC_A_RS);
        alu_src_b = (w_is_rtype || w_is_branch) ? SRC_B_RT : SRC_B_IMM;
        if (w_is_branch && alu_flag) begin
          pc_write = 1'b1;
          pc_src   = PC_SRC_ALUOUT;
        end
      end
      MEM: begin
        i_or_d    = 1'b1;
        mem_read  = w_is_lw;
        mem_write = w_is_sw;
      end
      WB: begin
        reg_write  = 1'b1;
        reg_dst    = w_is_rtype ? REG_DST_RD : REG_DST_RT;
        mem_to_reg = w_is_lw ? M2R_MDR : M2R_ALUOUT;
      end
`ifdef UNDEF_TRAP_EN
      TRAP: begin
        exc_flag   = 1'b1;
        reg_write  = 1'b1;
        reg_dst    = REG_DST_R26;
        mem_to_reg = M2R_PC;
        pc_write   = 1'b1;
        pc_src     = EXC_VECTOR_SEL;
      end
`endif
      default: ;
    endcase
    // the state register already sits in FETCH; suppress its read request too
    if (reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      exc_flag  = 1'b0;
      alu_fun   = ALU_ADD;
      sign      = 1'b0;
    end
  end

endmodule
